// File: rtl/multdiv_pkg.sv
// Shared types and constants for the HI/LO multiply/divide sequencer.
package multdiv_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [3:0] {
        OP_NONE,
        OP_MULT,
        OP_MULTU,
        OP_DIV,
        OP_DIVU,
        OP_MADD,
        OP_MADDU,
        OP_MSUB,
        OP_MSUBU,
        OP_MUL
    } decoded_op_t;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } multdiv_state_t;

    // sign/abs setup + 32 iterations + sign fixup
    localparam int DIV_CYCLES = 34;

    // Divide by zero: quotient is all ones, remainder is the raw dividend
    localparam word_t DIV0_QUOT = 32'hFFFF_FFFF;

    function automatic logic is_mult_class(decoded_op_t op);
        case (op)
            OP_MULT, OP_MULTU, OP_MADD, OP_MADDU,
            OP_MSUB, OP_MSUBU, OP_MUL:          return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    function automatic logic is_div_class(decoded_op_t op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_signed_op(decoded_op_t op);
        case (op)
            OP_MULT, OP_MADD, OP_MSUB, OP_MUL, OP_DIV: return 1'b1;
            default:                                   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multdiv_ctrl_div.sv
// Radix-2 restoring divider on unsigned magnitudes; one quotient bit per cycle.
// Signs are handled by the caller. abort cancels an in-flight divide.
import multdiv_pkg::*;

module div_radix2 (
    input  logic  clk,
    input  logic  resetn,
    input  logic  start,
    input  logic  abort,
    input  word_t dividend,
    input  word_t divisor,
    output word_t quotient,
    output word_t remainder,
    output logic  finish
);

    logic [5:0]  iter_cnt;
    logic        busy;
    word_t       quo_q;
    word_t       rem_q;
    word_t       dsr_q;
    logic [32:0] partial;
    logic [32:0] trial;

    // partial < 2*divisor, so bit 32 of trial is set exactly on a borrow
    assign partial = {rem_q, quo_q[31]};
    assign trial   = partial - {1'b0, dsr_q};

    // Shift-subtract iteration; finish pulses in the cycle after the last one
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            iter_cnt <= 6'd0;
            busy     <= 1'b0;
            quo_q    <= '0;
            rem_q    <= '0;
            dsr_q    <= '0;
            finish   <= 1'b0;
        end else begin
            finish <= 1'b0;
            if (abort) begin
                busy     <= 1'b0;
                iter_cnt <= 6'd0;
            end else if (start) begin
                rem_q    <= '0;
                quo_q    <= dividend;
                dsr_q    <= divisor;
                iter_cnt <= 6'd32;
                busy     <= 1'b1;
            end else if (busy) begin
                if (!trial[32]) begin
                    rem_q <= trial[31:0];
                    quo_q <= {quo_q[30:0], 1'b1};
                end else begin
                    rem_q <= partial[31:0];
                    quo_q <= {quo_q[30:0], 1'b0};
                end
                iter_cnt <= iter_cnt - 6'd1;
                if (iter_cnt == 6'd1) begin
                    busy   <= 1'b0;
                    finish <= 1'b1;
                end
            end
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/multdiv_ctrl.sv
// Execute-stage HI/LO multiply/divide sequencer.
// Build option: MULTDIV_ACCUM_EN enables MADD/MADDU/MSUB/MSUBU accumulation
// into the captured {hi_in, lo_in}; without it those ops behave as MULT/MULTU.
//
// state | meaning
// IDLE  | waiting for a multi-cycle op; stalls only in the accept cycle
// MUL   | multiply latency countdown
// DIV   | first cycle starts the divider, then waits for its finish
// DONE  | result presented with done; pipeline released
import multdiv_pkg::*;

module multdiv_ctrl #(
    parameter int MUL_LAT = 3
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        valid,
    input  decoded_op_t op,
    input  word_t       a,
    input  word_t       b,
    input  word_t       hi_in,
    input  word_t       lo_in,
    input  logic        flush,
    output logic        stall,
    output logic        done,
    output word_t       hi,
    output word_t       lo
);

    multdiv_state_t state_q, state_d;
    logic [5:0]     cnt_q;
    decoded_op_t    op_q;
    word_t          a_q, b_q;
    logic [63:0]    res_q;
    logic [63:0]    hilo_q;
    logic           accept;
    logic           div_start, div_finish;
    word_t          a_mag, b_mag, div_quo, div_rem, quo_fix, rem_fix;
    logic           sgn_q;
    logic [63:0]    a_ext, b_ext, product, mul_result, div_result;

`ifdef MULTDIV_ACCUM_EN
    logic [63:0]    acc_q;
`else
    logic           unused_accum;
    assign unused_accum = ^{hi_in, lo_in};
`endif

    assign accept = valid && (state_q == IDLE) && !flush
                 && (is_mult_class(op) || is_div_class(op));

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next state and handshake outputs; flush overrides every busy state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = is_mult_class(op) ? MUL : DIV;
            MUL:  if (cnt_q == 6'd0) state_d = DONE;
            DIV:  if (div_finish) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush && (state_q != IDLE)) state_d = IDLE;
        stall = accept || (state_q == MUL) || (state_q == DIV);
        done  = (state_q == DONE) && !flush;
    end

    // Operand capture at acceptance and the latency down-counter
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= 6'd0;
            op_q  <= OP_NONE;
            a_q   <= '0;
            b_q   <= '0;
`ifdef MULTDIV_ACCUM_EN
            acc_q <= '0;
`endif
        end else if (accept) begin
            cnt_q <= is_mult_class(op) ? 6'(MUL_LAT - 1) : 6'(DIV_CYCLES);
            op_q  <= op;
            a_q   <= a;
            b_q   <= b;
`ifdef MULTDIV_ACCUM_EN
            acc_q <= {hi_in, lo_in};
`endif
        end else if (((state_q == MUL) || (state_q == DIV)) && (cnt_q != 6'd0)) begin
            cnt_q <= cnt_q - 6'd1;
        end
    end

    // Multiply datapath: 64-bit product of sign- or zero-extended operands
    assign sgn_q   = is_signed_op(op_q);
    assign a_ext   = sgn_q ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
    assign b_ext   = sgn_q ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
    assign product = a_ext * b_ext;

    // Optional accumulate stage on the product
    always_comb begin
        mul_result = product;
`ifdef MULTDIV_ACCUM_EN
        case (op_q)
            OP_MADD, OP_MADDU: mul_result = acc_q + product;
            OP_MSUB, OP_MSUBU: mul_result = acc_q - product;
            default:           mul_result = product;
        endcase
`endif
    end

    // Divide: magnitudes in, sign fixup out; divide by zero is special-cased
    assign a_mag     = (sgn_q && a_q[31]) ? -a_q : a_q;
    assign b_mag     = (sgn_q && b_q[31]) ? -b_q : b_q;
    assign div_start = (state_q == DIV) && (cnt_q == 6'(DIV_CYCLES));
    assign quo_fix   = (sgn_q && (a_q[31] ^ b_q[31])) ? -div_quo : div_quo;
    assign rem_fix   = (sgn_q && a_q[31]) ? -div_rem : div_rem;
    assign div_result = (b_q == '0) ? {a_q, DIV0_QUOT} : {rem_fix, quo_fix};

    div_radix2 u_div (
        .clk       (clk),
        .resetn    (resetn),
        .start     (div_start),
        .abort     (flush),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .quotient  (div_quo),
        .remainder (div_rem),
        .finish    (div_finish)
    );

    // Pending result on entry to DONE; committed to HI/LO only if not flushed
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            res_q  <= '0;
            hilo_q <= '0;
        end else begin
            if ((state_q == MUL) && (state_d == DONE)) res_q <= mul_result;
            if ((state_q == DIV) && (state_d == DONE)) res_q <= div_result;
            if ((state_q == DONE) && !flush)           hilo_q <= res_q;
        end
    end

    assign hi = done ? res_q[63:32] : hilo_q[63:32];
    assign lo = done ? res_q[31:0]  : hilo_q[31:0];

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Scoreboard bench for multdiv_ctrl: the driver queues expected results at
// acceptance, the monitor pops and compares on every done pulse.
import multdiv_pkg::*;

module tb_multdiv_ctrl;

    localparam int MUL_LAT = 3;
    localparam int DIV_N   = 34;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        valid = 1'b0;
    logic        flush = 1'b0;
    decoded_op_t op = OP_NONE;
    word_t       a = '0, b = '0, hi_in = '0, lo_in = '0;
    logic        stall, done;
    word_t       hi, lo;

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    word_t last_hi = '0, last_lo = '0;

    typedef struct {
        string name;
        word_t hi;
        word_t lo;
        int    cyc;
    } exp_t;

    exp_t sb[$];

    multdiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .clk    (clk),
        .resetn (resetn),
        .valid  (valid),
        .op     (op),
        .a      (a),
        .b      (b),
        .hi_in  (hi_in),
        .lo_in  (lo_in),
        .flush  (flush),
        .stall  (stall),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (resetn && (done === 1'b1)) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_hi"}, hi, e.hi);
                check({e.name, "_lo"}, lo, e.lo);
                check({e.name, "_latency"}, 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic run_op(input string name, input decoded_op_t o,
                          input word_t va, input word_t vb,
                          input word_t vhi, input word_t vlo,
                          input word_t ehi, input word_t elo, input int n);
        bit stall_ok = 1'b1;
        bit seen = 1'b0;
        @(posedge clk); #1;
        valid = 1'b1; op = o; a = va; b = vb; hi_in = vhi; lo_in = vlo;
        @(negedge clk);
        check({name, "_stall_accept"}, 32'(stall), 32'd1);
        @(posedge clk); #1;
        sb.push_back('{name, ehi, elo, cyc + n});
        // valid stays high with scrambled inputs, as the held pipeline would
        op = (o == OP_MULTU) ? OP_DIV : OP_MULTU;
        a = $urandom; b = $urandom; hi_in = $urandom; lo_in = $urandom;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (stall !== 1'b1) stall_ok = 1'b0;
        end
        check({name, "_stall_busy"}, 32'(stall_ok), 32'd1);
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: no done within 60 cycles, required one", name);
        end else begin
            check({name, "_stall_done"}, 32'(stall), 32'd0);
        end
        @(posedge clk); #1;
        valid = 1'b0;
        @(negedge clk);
        check({name, "_no_reaccept"}, 32'(stall), 32'd0);
        check({name, "_commit_hi"}, hi, ehi);
        check({name, "_commit_lo"}, lo, elo);
        last_hi = ehi;
        last_lo = elo;
    endtask

    task automatic kill_test(input string name, input bit use_reset);
        @(posedge clk); #1;
        valid = 1'b1; op = OP_DIV; a = 32'hFFFF_FFF9; b = 32'd2;
        @(posedge clk); #1;
        repeat (10) @(posedge clk);
        #1;
        valid = 1'b0;
        if (use_reset) begin
            resetn = 1'b0;
            #1;
            check({name, "_rst_stall"}, 32'(stall), 32'd0);
            check({name, "_rst_done"}, 32'(done), 32'd0);
            check({name, "_rst_hi"}, hi, 32'd0);
            check({name, "_rst_lo"}, lo, 32'd0);
        end else begin
            flush = 1'b1;
        end
        @(posedge clk); #1;
        flush = 1'b0;
        resetn = 1'b1;
        if (use_reset) begin
            last_hi = '0;
            last_lo = '0;
        end
        @(negedge clk);
        check({name, "_stall_after"}, 32'(stall), 32'd0);
        check({name, "_done_after"}, 32'(done), 32'd0);
        check({name, "_hi_kept"}, hi, last_hi);
        check({name, "_lo_kept"}, lo, last_lo);
        repeat (45) @(negedge clk);
        check({name, "_hi_final"}, hi, last_hi);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_stall", 32'(stall), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        resetn = 1'b1;

        // flush together with valid in IDLE: not accepted
        @(posedge clk); #1;
        valid = 1'b1; flush = 1'b1; op = OP_DIV; a = 32'd9; b = 32'd3;
        @(negedge clk);
        check("idle_flush_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("idle_flush_not_accepted", 32'(stall), 32'd0);

        run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0,
               32'h0000_0001, 32'hFFFF_FFFE, MUL_LAT);
        run_op("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'd0, 32'd0,
               32'hFFFF_FFFF, 32'hFFFF_FFEB, MUL_LAT);
        run_op("mul_negneg", OP_MUL, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd0, 32'd0,
               32'h0000_0000, 32'h0000_0006, MUL_LAT);
        run_op("div_neg_a", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_N);
        run_op("div_neg_b", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'd0, 32'd0,
               32'h0000_0001, 32'hFFFF_FFFD, DIV_N);
        run_op("divu_zero", OP_DIVU, 32'd100, 32'd0, 32'd0, 32'd0,
               32'd100, 32'hFFFF_FFFF, DIV_N);
        run_op("div_zero_neg", OP_DIV, 32'hFFFF_FFF8, 32'd0, 32'd0, 32'd0,
               32'hFFFF_FFF8, 32'hFFFF_FFFF, DIV_N);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0,
               32'h0000_0000, 32'h8000_0000, DIV_N);
        run_op("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'd10, 32'd0, 32'd0,
               32'h0000_0005, 32'h1999_9999, DIV_N);
`ifdef MULTDIV_ACCUM_EN
        run_op("maddu_carry", OP_MADDU, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF,
               32'h0000_0001, 32'h0000_0000, MUL_LAT);
        run_op("msub_neg", OP_MSUB, 32'd3, 32'd5, 32'd0, 32'd10,
               32'hFFFF_FFFF, 32'hFFFF_FFFB, MUL_LAT);
        run_op("madd_signed", OP_MADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd5,
               32'h0000_0000, 32'h0000_0004, MUL_LAT);
`else
        run_op("maddu_plain", OP_MADDU, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF,
               32'h0000_0000, 32'h0000_0001, MUL_LAT);
        run_op("msub_plain", OP_MSUB, 32'd3, 32'd5, 32'd0, 32'd10,
               32'h0000_0000, 32'h0000_000F, MUL_LAT);
        run_op("madd_plain", OP_MADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd5,
               32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT);
`endif

        kill_test("flush_div", 1'b0);
        run_op("divu_after_flush", OP_DIVU, 32'd100, 32'd7, 32'd0, 32'd0,
               32'h0000_0002, 32'h0000_000E, DIV_N);

        kill_test("reset_div", 1'b1);
        run_op("multu_after_reset", OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd0,
               32'h0000_0000, 32'h0000_002A, MUL_LAT);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
